zx8x_tape_loader: RTL and testbench
===================================

Name: zx8x_tape_loader

Overview:
Sequencer for the fast tape-load path.
- Watches CPU opcode fetches for the ROM LOAD entry point.
- While the CPU spins in the patched ROM loop, copies the tape buffer into system RAM through a request/acknowledge write port.
- Drives the patch-control signals: patch-active, loop-exit select and return-address byte.
- Sits between the tape buffer BRAM, the SDRAM write mux and the ROM patch overlay.

Parameters:
TAPE_AW, 14, tape buffer address width (16 KB buffer)
ZX81_ENTRY, 16'h0347, ZX81 LOAD entry PC
ZX81_EXIT, 16'h03C3, first PC past the ZX81 loader range
ZX80_ENTRY, 16'h0207, ZX80 LOAD entry PC
ZX80_EXIT, 16'h024D, first PC past the ZX80 loader range

Ports:
clk_sys  in  1  system clock (52 MHz)
reset_n  in  1  asynchronous active-low reset
zx81  in  1  model select: 1 = ZX81, 0 = ZX80
nM1  in  1  CPU M1, active low
addr  in  16  CPU address bus
tape_ready  in  1  tape buffer holds a complete image
tape_len  in  TAPE_AW+1  image length in bytes
p_format  in  1  1 = .p image (base 16'h4009), 0 = .o image (base 16'h4000)
tape_addr  out  TAPE_AW  tape buffer read address
tape_data  in  8  tape buffer data, valid 1 cycle after tape_addr changes
wr_req  out  1  RAM write request
wr_addr  out  16  RAM write address
wr_data  out  8  RAM write data
wr_ack  in  1  RAM write accepted, 1-cycle pulse
active  out  1  ROM patch overlay enabled; RAM address mux owned by loader
patch_done  out  1  1 = patch loop byte is SCF (exit), 0 = NOP (spin)
patch_ret  out  8  low byte of patch JP target
done  out  1  1-cycle pulse when the last byte is acknowledged

Behaviour:
- Reset values: state = IDLE; active, patch_done, wr_req, done = 0; tape_addr, wr_addr, wr_data = 0. Async assert, sync deassert is the caller's job.
- patch_ret is combinational: zx81 ? 8'h07 : 8'h03.
- m1_fall = registered nM1 was 1 and current nM1 is 0. It is the only point where addr is sampled as a PC.
- ENTRY = zx81 ? ZX81_ENTRY : ZX80_ENTRY. EXIT is selected the same way.
- IDLE:
  - On m1_fall & addr==ENTRY & tape_ready: set active=1, patch_done=0, tape_addr=0, byte index n=0.
  - If tape_len==0, go to DONE. Otherwise go to FETCH.
  - In IDLE, an entry hit without tape_ready is ignored.
- FETCH: 1 wait cycle for the buffer read, then go to WRITE.
- WRITE:
  - Entry cycle: latch wr_data=tape_data and wr_addr=(p_format ? 16'h4009 : 16'h4000)+n, then set wr_req=1.
  - Hold wr_req, wr_addr and wr_data stable until wr_ack.
  - On wr_ack: drop wr_req the next cycle.
  - If n+1==tape_len or wr_addr==16'hFFFF (RAM ceiling), go to DONE. Otherwise n++, tape_addr++, go to FETCH.
- Throughput: at best 1 byte per 3 cycles plus ack latency.
- DONE:
  - On entry: patch_done=1 and a 1-cycle done pulse.
  - Hold active=1 until exit.
- Exit: m1_fall with addr<ENTRY or addr>=EXIT, in any non-IDLE state.
  - If wr_req is pending, complete that handshake (wait for wr_ack), then go to IDLE.
  - Otherwise go to IDLE immediately.
  - active=0 and patch_done=0 on the IDLE transition. done does not pulse on an abort.
- tape_ready or tape_len changing after the start are ignored until IDLE.
- An entry hit while not in IDLE is ignored.
- zx81 must be static while active. It is sampled at entry for EXIT selection.
- wr_ack outside WRITE is ignored.
- tape_addr saturates at 2^TAPE_AW-1 and never wraps; tape_len is at most 2^TAPE_AW.

Test Plan:
- ZX81, .p, tape_len=3 (bytes AA, BB, CC), zero-latency ack; M1 fetch at 0347 -> active=1 next cycle; writes 4009=AA, 400A=BB, 400B=CC in order; one done pulse; patch_done=1; M1 at 0207 -> active=0.
- ZX80, .o, tape_len=2, wr_ack delayed 5 cycles -> wr_req/wr_addr/wr_data held stable 5 cycles; writes 4000, 4001; patch_ret=03.
- M1 at 0347 with tape_ready=0 -> active stays 0, no wr_req. M1 at 0348 with tape_ready=1 -> no start.
- tape_len=0 at entry -> DONE directly: patch_done=1, done pulse, zero writes.
- M1 at 0500 mid-transfer with wr_req high -> wr_req held until wr_ack, then IDLE, active=0, no done pulse.
- reset_n low mid-WRITE -> wr_req, active and patch_done drop asynchronously; after release, a new entry restarts at tape_addr=0.

Source files
------------

// File: rtl/zx8x_tape_loader.sv
// zx8x_tape_loader
// Fast tape-load sequencer for the ZX80/ZX81 core.
//
// Watches opcode fetches for the ROM LOAD entry point. Once the CPU enters
// the loader, the ROM patch overlay is enabled so the CPU spins in a small
// patched loop. Meanwhile the tape buffer image is copied into system RAM
// through a request/acknowledge write port. When the copy finishes, the
// loop byte flips to its exit form. The overlay is released when the CPU
// fetches from outside the loader range.
//
// Ports:
//   clk_sys     system clock
//   reset_n     asynchronous active-low reset
//   zx81        model select (1 = ZX81, 0 = ZX80)
//   nM1         CPU M1, active low
//   addr        CPU address bus
//   tape_ready  tape buffer holds a complete image
//   tape_len    image length in bytes
//   p_format    1 = .p image (base 4009h), 0 = .o image (base 4000h)
//   tape_addr   tape buffer read address
//   tape_data   tape buffer read data (one cycle after tape_addr)
//   wr_req      RAM write request, held until wr_ack
//   wr_addr     RAM write address
//   wr_data     RAM write data
//   wr_ack      RAM write accepted (one-cycle pulse)
//   active      patch overlay enabled / loader owns the RAM address mux
//   patch_done  patch loop byte is SCF (exit) rather than NOP (spin)
//   patch_ret   low byte of the patch JP target
//   done        one-cycle pulse when the last byte is acknowledged
module zx8x_tape_loader #(
  parameter int          TAPE_AW    = 14,
  parameter logic [15:0] ZX81_ENTRY = 16'h0347,
  parameter logic [15:0] ZX81_EXIT  = 16'h03C3,
  parameter logic [15:0] ZX80_ENTRY = 16'h0207,
  parameter logic [15:0] ZX80_EXIT  = 16'h024D
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               zx81,
  input  logic               nM1,
  input  logic [15:0]        addr,
  input  logic               tape_ready,
  input  logic [TAPE_AW:0]   tape_len,
  input  logic               p_format,
  output logic [TAPE_AW-1:0] tape_addr,
  input  logic [7:0]         tape_data,
  output logic               wr_req,
  output logic [15:0]        wr_addr,
  output logic [7:0]         wr_data,
  input  logic               wr_ack,
  output logic               active,
  output logic               patch_done,
  output logic [7:0]         patch_ret,
  output logic               done
);

  // S_DRAIN finishes an in-flight RAM write after an abort so the SDRAM
  // mux never sees a request withdrawn before it was accepted.
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic               nm1_q;
  logic               zx81_q, zx81_d;
  logic               active_q, active_d;
  logic               patch_done_q, patch_done_d;
  logic               wr_req_q, wr_req_d;
  logic [15:0]        wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic               done_q, done_d;
  logic [TAPE_AW-1:0] tape_addr_q, tape_addr_d;
  logic [TAPE_AW:0]   n_q, n_d;

  logic               m1_fall;
  logic [15:0]        entry_pc;
  logic [15:0]        run_entry;
  logic [15:0]        run_exit;
  logic               entry_hit;
  logic               exit_hit;
  logic [TAPE_AW:0]   n_next;
  logic               last_byte;
  logic [15:0]        ram_base;

  // Entry uses the live model select; the exit window uses the model
  // captured at entry so the range cannot move under a running load.
  always_comb begin
    m1_fall   = nm1_q & ~nM1;
    entry_pc  = zx81 ? ZX81_ENTRY : ZX80_ENTRY;
    run_entry = zx81_q ? ZX81_ENTRY : ZX80_ENTRY;
    run_exit  = zx81_q ? ZX81_EXIT : ZX80_EXIT;
    entry_hit = m1_fall && (addr == entry_pc) && tape_ready;
    exit_hit  = m1_fall && ((addr < run_entry) || (addr >= run_exit));
    n_next    = n_q + (TAPE_AW+1)'(1);
    last_byte = (n_next == tape_len) || (wr_addr_q == 16'hFFFF);
    ram_base  = p_format ? 16'h4009 : 16'h4000;
  end

  // Next-state and output logic. Every register holds by default; the
  // done pulse defaults low so it is only ever one cycle wide.
  always_comb begin
    state_d      = state_q;
    zx81_d       = zx81_q;
    active_d     = active_q;
    patch_done_d = patch_done_q;
    wr_req_d     = wr_req_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    done_d       = 1'b0;
    tape_addr_d  = tape_addr_q;
    n_d          = n_q;

    case (state_q)
      S_IDLE: begin
        if (entry_hit) begin
          active_d     = 1'b1;
          patch_done_d = 1'b0;
          tape_addr_d  = '0;
          n_d          = '0;
          zx81_d       = zx81;
          if (tape_len == '0) begin
            state_d      = S_DONE;
            patch_done_d = 1'b1;
            done_d       = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        if (exit_hit) begin
          state_d      = S_IDLE;
          active_d     = 1'b0;
          patch_done_d = 1'b0;
        end else begin
          state_d = S_WRITE;
        end
      end

      // First WRITE cycle (no request yet) captures the buffer byte and
      // address; later cycles hold them until the RAM side accepts.
      S_WRITE: begin
        if (!wr_req_q) begin
          if (exit_hit) begin
            state_d      = S_IDLE;
            active_d     = 1'b0;
            patch_done_d = 1'b0;
          end else begin
            wr_data_d = tape_data;
            wr_addr_d = ram_base + 16'(n_q);
            wr_req_d  = 1'b1;
          end
        end else if (wr_ack) begin
          wr_req_d = 1'b0;
          if (exit_hit) begin
            state_d      = S_IDLE;
            active_d     = 1'b0;
            patch_done_d = 1'b0;
          end else if (last_byte) begin
            state_d      = S_DONE;
            patch_done_d = 1'b1;
            done_d       = 1'b1;
          end else begin
            state_d = S_FETCH;
            n_d     = n_next;
            if (tape_addr_q != '1) begin
              tape_addr_d = tape_addr_q + TAPE_AW'(1);
            end
          end
        end else if (exit_hit) begin
          state_d = S_DRAIN;
        end
      end

      S_DONE: begin
        if (exit_hit) begin
          state_d      = S_IDLE;
          active_d     = 1'b0;
          patch_done_d = 1'b0;
        end
      end

      S_DRAIN: begin
        if (wr_ack) begin
          wr_req_d     = 1'b0;
          state_d      = S_IDLE;
          active_d     = 1'b0;
          patch_done_d = 1'b0;
        end
      end

      default: begin
        state_d      = S_IDLE;
        active_d     = 1'b0;
        patch_done_d = 1'b0;
        wr_req_d     = 1'b0;
      end
    endcase
  end

  // State register. nM1 resets high so no M1 edge is seen coming out
  // of reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      nm1_q        <= 1'b1;
      zx81_q       <= 1'b0;
      active_q     <= 1'b0;
      patch_done_q <= 1'b0;
      wr_req_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      done_q       <= 1'b0;
      tape_addr_q  <= '0;
      n_q          <= '0;
    end else begin
      state_q      <= state_d;
      nm1_q        <= nM1;
      zx81_q       <= zx81_d;
      active_q     <= active_d;
      patch_done_q <= patch_done_d;
      wr_req_q     <= wr_req_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      done_q       <= done_d;
      tape_addr_q  <= tape_addr_d;
      n_q          <= n_d;
    end
  end

  assign tape_addr  = tape_addr_q;
  assign wr_req     = wr_req_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign active     = active_q;
  assign patch_done = patch_done_q;
  assign done       = done_q;
  assign patch_ret  = zx81 ? 8'h07 : 8'h03;

endmodule

// File: tb/tb_zx8x_tape_loader.sv
// tb_zx8x_tape_loader
// Directed bench for zx8x_tape_loader. A small tape buffer model feeds
// the loader; a RAM responder acknowledges writes after a programmable
// latency and compares each accepted write against a scoreboard queue
// filled when the tape image is loaded.
module tb_zx8x_tape_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        zx81 = 1'b1;
  logic        nM1 = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic        tape_ready = 1'b0;
  logic [14:0] tape_len = '0;
  logic        p_format = 1'b1;
  logic [13:0] tape_addr;
  logic [7:0]  tape_data = 8'h00;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack = 1'b0;
  logic        active;
  logic        patch_done;
  logic [7:0]  patch_ret;
  logic        done;

  zx8x_tape_loader dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .zx81       (zx81),
    .nM1        (nM1),
    .addr       (addr),
    .tape_ready (tape_ready),
    .tape_len   (tape_len),
    .p_format   (p_format),
    .tape_addr  (tape_addr),
    .tape_data  (tape_data),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .active     (active),
    .patch_done (patch_done),
    .patch_ret  (patch_ret),
    .done       (done)
  );

  always #10 clk_sys = ~clk_sys;

  int          compared = 0;
  int          mismatched = 0;
  int          ack_lat = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          req_cnt = 0;
  int          wait_cnt = 0;
  logic        wr_req_prev = 1'b0;
  logic [15:0] hold_addr = '0;
  logic [7:0]  hold_data = '0;
  logic [23:0] exp_q[$];
  logic [7:0]  mem [0:15];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Tape buffer: registered read, so data follows tape_addr by one cycle.
  always @(posedge clk_sys) begin
    tape_data <= mem[tape_addr[3:0]];
  end

  // RAM responder and event monitor, sampled on the falling edge.
  always @(negedge clk_sys) begin
    logic [23:0] expv;
    wr_ack = 1'b0;
    if (wr_req && !wr_req_prev) req_cnt++;
    wr_req_prev = wr_req;
    done_cnt += int'(done);
    if (reset_n && wr_req) begin
      if (wait_cnt == 0) begin
        hold_addr = wr_addr;
        hold_data = wr_data;
      end else begin
        checkOutput("hold_addr", 32'(wr_addr), 32'(hold_addr));
        checkOutput("hold_data", 32'(wr_data), 32'(hold_data));
      end
      if (wait_cnt >= ack_lat) begin
        wr_ack = 1'b1;
        wr_cnt++;
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
        checkOutput("sb_write", 32'({wr_addr, wr_data}), 32'(expv));
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // One opcode fetch: nM1 low for one cycle with the PC on addr.
  task automatic applyStimulus(input logic [15:0] pc);
    @(negedge clk_sys);
    addr = pc;
    nM1  = 1'b0;
    @(negedge clk_sys);
    nM1  = 1'b1;
  endtask

  // Fill the tape buffer with seed, seed+11h, ... and queue the
  // RAM writes the loader should produce from it.
  task automatic loadTape(input int len, input logic [15:0] base, input logic [7:0] seed);
    logic [7:0] b;
    tape_len = 15'(len);
    for (int i = 0; i < len; i++) begin
      b = seed + 8'(i * 17);
      mem[i] = b;
      exp_q.push_back({base + 16'(i), b});
    end
  endtask

  task automatic waitDone(input int target, input string tag);
    int k = 0;
    while (done_cnt < target && k < 200) begin
      @(negedge clk_sys);
      k++;
    end
    checkOutput(tag, 32'(done_cnt), 32'(target));
  endtask

  task automatic waitReq(input string tag);
    int k = 0;
    while (!wr_req && k < 50) begin
      @(negedge clk_sys);
      k++;
    end
    checkOutput(tag, 32'(wr_req), 32'd1);
  endtask

  task automatic waitIdle(input string tag);
    int k = 0;
    while (active && k < 100) begin
      @(negedge clk_sys);
      k++;
    end
    checkOutput(tag, 32'(active), 32'd0);
  endtask

  initial begin
    int w0, d0, r0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    // Reset state
    repeat (2) @(negedge clk_sys);
    checkOutput("rst_active", 32'(active), 32'd0);
    checkOutput("rst_patch_done", 32'(patch_done), 32'd0);
    checkOutput("rst_wr_req", 32'(wr_req), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_tape_addr", 32'(tape_addr), 32'd0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // ZX81 .p image, three bytes, zero-latency ack
    $display("[TB] ZX81 .p transfer");
    zx81 = 1'b1; p_format = 1'b1; tape_ready = 1'b1; ack_lat = 0;
    loadTape(3, 16'h4009, 8'hAA);
    checkOutput("zx81_patch_ret", 32'(patch_ret), 32'h07);
    applyStimulus(16'h0347);
    checkOutput("zx81_active", 32'(active), 32'd1);
    checkOutput("zx81_patch_done_early", 32'(patch_done), 32'd0);
    waitDone(1, "zx81_done");
    checkOutput("zx81_writes", 32'(wr_cnt), 32'd3);
    checkOutput("zx81_queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("zx81_patch_done", 32'(patch_done), 32'd1);
    checkOutput("zx81_tape_addr", 32'(tape_addr), 32'd2);
    applyStimulus(16'h0350);
    repeat (3) @(negedge clk_sys);
    checkOutput("zx81_hold_active", 32'(active), 32'd1);
    checkOutput("zx81_single_done", 32'(done_cnt), 32'd1);
    applyStimulus(16'h0207);
    checkOutput("zx81_exit_active", 32'(active), 32'd0);
    checkOutput("zx81_exit_patch_done", 32'(patch_done), 32'd0);

    // ZX80 .o image, two bytes, ack delayed five cycles
    $display("[TB] ZX80 .o transfer");
    zx81 = 1'b0; p_format = 1'b0; ack_lat = 5;
    loadTape(2, 16'h4000, 8'h11);
    @(negedge clk_sys);
    checkOutput("zx80_patch_ret", 32'(patch_ret), 32'h03);
    applyStimulus(16'h0207);
    checkOutput("zx80_active", 32'(active), 32'd1);
    waitDone(2, "zx80_done");
    checkOutput("zx80_writes", 32'(wr_cnt), 32'd5);
    checkOutput("zx80_queue_empty", 32'(exp_q.size()), 32'd0);
    applyStimulus(16'h0100);
    checkOutput("zx80_exit_active", 32'(active), 32'd0);

    // Entry hits that must not start a load
    $display("[TB] ignored entries");
    zx81 = 1'b1; p_format = 1'b1; ack_lat = 0; tape_ready = 1'b0;
    r0 = req_cnt;
    applyStimulus(16'h0347);
    repeat (8) @(negedge clk_sys);
    checkOutput("noready_active", 32'(active), 32'd0);
    checkOutput("noready_req", 32'(req_cnt), 32'(r0));
    tape_ready = 1'b1;
    applyStimulus(16'h0348);
    repeat (4) @(negedge clk_sys);
    checkOutput("wrongpc_active", 32'(active), 32'd0);
    checkOutput("wrongpc_req", 32'(req_cnt), 32'(r0));

    // Empty image goes straight to DONE
    $display("[TB] empty image");
    tape_len = '0;
    w0 = wr_cnt; d0 = done_cnt;
    applyStimulus(16'h0347);
    checkOutput("empty_active", 32'(active), 32'd1);
    repeat (3) @(negedge clk_sys);
    checkOutput("empty_patch_done", 32'(patch_done), 32'd1);
    checkOutput("empty_done", 32'(done_cnt), 32'(d0 + 1));
    checkOutput("empty_writes", 32'(wr_cnt), 32'(w0));
    applyStimulus(16'h0500);
    checkOutput("empty_exit_active", 32'(active), 32'd0);

    // Abort with a write in flight: handshake completes, no done pulse
    $display("[TB] abort mid-transfer");
    ack_lat = 5;
    loadTape(3, 16'h4009, 8'h30);
    w0 = wr_cnt; d0 = done_cnt;
    applyStimulus(16'h0347);
    waitReq("abort_req_seen");
    applyStimulus(16'h0500);
    checkOutput("abort_req_held", 32'(wr_req), 32'd1);
    checkOutput("abort_active_held", 32'(active), 32'd1);
    waitIdle("abort_idle");
    checkOutput("abort_req_dropped", 32'(wr_req), 32'd0);
    checkOutput("abort_writes", 32'(wr_cnt), 32'(w0 + 1));
    checkOutput("abort_no_done", 32'(done_cnt), 32'(d0));
    checkOutput("abort_left", 32'(exp_q.size()), 32'd2);
    exp_q.delete();

    // Asynchronous reset mid-WRITE, then a clean restart
    $display("[TB] reset mid-write");
    loadTape(3, 16'h4009, 8'h51);
    applyStimulus(16'h0347);
    waitReq("rstw_req_seen");
    @(posedge clk_sys);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("rstw_wr_req", 32'(wr_req), 32'd0);
    checkOutput("rstw_active", 32'(active), 32'd0);
    checkOutput("rstw_patch_done", 32'(patch_done), 32'd0);
    exp_q.delete();
    @(negedge clk_sys);
    reset_n = 1'b1;
    ack_lat = 0;
    d0 = done_cnt;
    loadTape(3, 16'h4009, 8'h62);
    applyStimulus(16'h0347);
    checkOutput("restart_tape_addr", 32'(tape_addr), 32'd0);
    waitDone(d0 + 1, "restart_done");
    checkOutput("restart_queue_empty", 32'(exp_q.size()), 32'd0);
    applyStimulus(16'h0000);
    checkOutput("restart_exit_active", 32'(active), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
